// File: rtl/gth_lane_packer_pkg.sv
// gth_pack_pkg: shared types and constants for the GTH lane packer.
//   line_state_e  : line state encoding (IDLE=0, TRAIN=1, RUN=2)
//   DEF_IDLE_SYM  : default idle / underrun fill symbol
//   DEF_TRAIN_SYM : default training symbol
//   slot_offset() : bit offset of (channel, slot) inside the packed word bus
package gth_pack_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } line_state_e;

  localparam logic [9:0] DEF_IDLE_SYM  = 10'h354;
  localparam logic [9:0] DEF_TRAIN_SYM = 10'h0FF;

  // Channel c occupies RATIO consecutive symbols; slot k sits k symbols in.
  function automatic int unsigned slot_offset(input int unsigned ch,
                                              input int unsigned slot,
                                              input int unsigned ratio,
                                              input int unsigned sym_w);
    return (ch * ratio + slot) * sym_w;
  endfunction

endpackage

// File: rtl/gth_lane_packer_lane.sv
// gth_pack_lane: one channel of the packer. Collects slots 0..RATIO-2 in a
// staging register and, on the last-slot cycle, registers the full word
// (staged slots plus the current fill symbol) into the output register.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_phase        : current slot index 0..RATIO-1
//   i_last         : high on the last slot of a word
//   i_fill         : symbol for the current slot
//   o_word         : registered word, slot k at [k*SYM_W +: SYM_W]
module gth_pack_lane
  import gth_pack_pkg::*;
#(
  parameter int unsigned      SYM_W    = 10,
  parameter int unsigned      RATIO    = 2,
  parameter logic [SYM_W-1:0] IDLE_SYM = DEF_IDLE_SYM
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [$clog2(RATIO)-1:0] i_phase,
  input  logic                     i_last,
  input  logic [SYM_W-1:0]         i_fill,
  output logic [RATIO*SYM_W-1:0]   o_word
);

  localparam int unsigned PH_W = $clog2(RATIO);

  // The last slot bypasses staging and goes straight into the word register.
  logic [SYM_W-1:0]       r_slot [RATIO-1];
  logic [RATIO*SYM_W-1:0] r_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) r_slot[k] <= IDLE_SYM;
      r_word <= {RATIO{IDLE_SYM}};
    end else begin
      for (int unsigned k = 0; k < RATIO - 1; k++) begin
        if (i_phase == PH_W'(k)) r_slot[k] <= i_fill;
      end
      if (i_last) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          r_word[k*SYM_W +: SYM_W] <= r_slot[k];
        end
        r_word[(RATIO-1)*SYM_W +: SYM_W] <= i_fill;
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/gth_lane_packer.sv
// gth_lane_packer: packs NUM_CH per-pixel-clock symbols into RATIO-symbol
// words per channel for the GTH user-data bus, generates the word-rate phase
// clock and runs the line state machine (IDLE fill / TRAIN pattern / RUN).
// Ports:
//   clk, reset  : pixel clock, synchronous active-high reset
//   enable      : request the line leave IDLE
//   train_req   : pulse, request a training burst while in RUN
//   in_valid    : in_sym valid this cycle
//   in_sym      : channel c at [c*SYM_W +: SYM_W]
//   out_word    : channel c at [c*RATIO*SYM_W +: RATIO*SYM_W], slot k at k*SYM_W
//   out_valid   : one-cycle pulse, out_word updated
//   word_clk    : registered word-rate phase clock
//   line_state  : 0 IDLE, 1 TRAIN, 2 RUN
//   underrun    : one-cycle pulse after a RUN slot with in_valid=0
//   underrun_cnt: saturating underrun slot count (only with
//                 GTH_PACK_UNDERRUN_CNT_EN defined)
module gth_lane_packer
  import gth_pack_pkg::*;
#(
  parameter int unsigned      NUM_CH      = 3,
  parameter int unsigned      SYM_W       = 10,
  parameter int unsigned      RATIO       = 2,
  parameter int unsigned      TRAIN_WORDS = 16,
  parameter logic [SYM_W-1:0] IDLE_SYM    = DEF_IDLE_SYM,
  parameter logic [SYM_W-1:0] TRAIN_SYM   = DEF_TRAIN_SYM
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          train_req,
  input  logic                          in_valid,
  input  logic [NUM_CH*SYM_W-1:0]       in_sym,
  output logic [NUM_CH*RATIO*SYM_W-1:0] out_word,
  output logic                          out_valid,
  output logic                          word_clk,
  output logic [1:0]                    line_state,
  output logic                          underrun
`ifdef GTH_PACK_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int unsigned PH_W  = $clog2(RATIO);
  localparam int unsigned CNT_W = $clog2(TRAIN_WORDS + 1);

  logic [PH_W-1:0]  r_phase;
  logic             w_last;
  line_state_e      r_state;
  logic [CNT_W-1:0] r_train_cnt;
  logic             r_train_pending;
  logic             r_out_valid;
  logic             r_word_clk;
  logic             r_underrun;
  logic             w_underrun;
  logic [SYM_W-1:0] w_fill [NUM_CH];

  assign w_last     = (r_phase == PH_W'(RATIO - 1));
  assign w_underrun = (r_state == RUN) && !in_valid;

  // Free-running slot counter, also drives the word-rate clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase     <= '0;
      r_out_valid <= 1'b0;
      r_word_clk  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_phase     <= w_last ? '0 : r_phase + 1'b1;
      r_out_valid <= w_last;
      r_word_clk  <= (r_phase < PH_W'(RATIO / 2));
      r_underrun  <= w_underrun;
    end
  end

  // Transitions only at word boundaries so a word never mixes modes.
  // A train_req on the boundary cycle is folded in directly, enable=0 wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_train_cnt     <= '0;
      r_train_pending <= 1'b0;
    end else begin
      if (r_state == RUN && train_req) r_train_pending <= 1'b1;
      if (w_last) begin
        case (r_state)
          IDLE: begin
            if (enable) begin
              r_state     <= TRAIN;
              r_train_cnt <= '0;
            end
          end
          TRAIN: begin
            if (!enable) begin
              r_state         <= IDLE;
              r_train_pending <= 1'b0;
            end else begin
              r_train_cnt <= r_train_cnt + 1'b1;
              if (r_train_cnt == CNT_W'(TRAIN_WORDS - 1)) r_state <= RUN;
            end
          end
          RUN: begin
            if (!enable) begin
              r_state         <= IDLE;
              r_train_pending <= 1'b0;
            end else if (r_train_pending || train_req) begin
              r_state         <= TRAIN;
              r_train_cnt     <= '0;
              r_train_pending <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_fill[c] = IDLE_SYM;
      case (r_state)
        TRAIN:   w_fill[c] = TRAIN_SYM;
        RUN:     if (in_valid) w_fill[c] = in_sym[c*SYM_W +: SYM_W];
        default: w_fill[c] = IDLE_SYM;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    gth_pack_lane #(
      .SYM_W    (SYM_W),
      .RATIO    (RATIO),
      .IDLE_SYM (IDLE_SYM)
    ) u_lane (
      .i_clk   (clk),
      .i_reset (reset),
      .i_phase (r_phase),
      .i_last  (w_last),
      .i_fill  (w_fill[c]),
      .o_word  (out_word[slot_offset(c, 0, RATIO, SYM_W) +: RATIO*SYM_W])
    );
  end

`ifdef GTH_PACK_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_underrun_cnt <= '0;
    end else if (w_last && r_state == IDLE && enable) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun && r_underrun_cnt != '1) begin
      r_underrun_cnt <= r_underrun_cnt + 1'b1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign out_valid  = r_out_valid;
  assign word_clk   = r_word_clk;
  assign line_state = r_state;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_gth_lane_packer.sv
module tb_gth_lane_packer;

  localparam logic [9:0] IDL = 10'h354;
  localparam logic [9:0] TRN = 10'h0FF;
  localparam int         TW  = 16;

  logic        clk = 1'b0;
  logic        reset, enable, train_req, in_valid;
  logic [29:0] in_sym;

  logic [59:0] ow0;
  logic [79:0] ow1;
  logic        ov0, ov1, wc0, wc1, ur0, ur1;
  logic [1:0]  ls0, ls1;
`ifdef GTH_PACK_UNDERRUN_CNT_EN
  logic [15:0] uc0, uc1;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  gth_lane_packer u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .train_req(train_req),
    .in_valid(in_valid), .in_sym(in_sym), .out_word(ow0), .out_valid(ov0),
    .word_clk(wc0), .line_state(ls0), .underrun(ur0)
`ifdef GTH_PACK_UNDERRUN_CNT_EN
    , .underrun_cnt(uc0)
`endif
  );

  gth_lane_packer #(.NUM_CH(2), .RATIO(4)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .train_req(train_req),
    .in_valid(in_valid), .in_sym(in_sym[19:0]), .out_word(ow1), .out_valid(ov1),
    .word_clk(wc1), .line_state(ls1), .underrun(ur1)
`ifdef GTH_PACK_UNDERRUN_CNT_EN
    , .underrun_cnt(uc1)
`endif
  );

  // Reference model: symbol stream per channel, grouped into words of R symbols.
  int         mr[2] = '{2, 4};
  int         mn[2] = '{3, 2};
  int         m_phase[2], m_state[2], m_tcnt[2], m_ucnt[2];
  bit         m_pend[2], m_valid[2], m_under[2], m_wclk[2];
  logic [9:0] m_acc[2][8][3];
  logic [9:0] m_word[2][8][3];

  task automatic model_step(input int d);
    bit         last;
    logic [9:0] s;
    if (reset) begin
      m_phase[d] = 0; m_state[d] = 0; m_tcnt[d] = 0; m_pend[d] = 0;
      m_valid[d] = 0; m_under[d] = 0; m_wclk[d] = 0; m_ucnt[d] = 0;
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < 3; c++) begin
          m_acc[d][k][c]  = IDL;
          m_word[d][k][c] = IDL;
        end
      return;
    end
    last       = (m_phase[d] == mr[d] - 1);
    m_wclk[d]  = (m_phase[d] < mr[d] / 2);
    m_under[d] = (m_state[d] == 2) && !in_valid;
    if (m_under[d] && m_ucnt[d] < 65535) m_ucnt[d]++;
    for (int c = 0; c < mn[d]; c++) begin
      if (m_state[d] == 0)      s = IDL;
      else if (m_state[d] == 1) s = TRN;
      else                      s = in_valid ? in_sym[c*10 +: 10] : IDL;
      m_acc[d][m_phase[d]][c] = s;
    end
    m_valid[d] = last;
    if (m_state[d] == 2 && train_req) m_pend[d] = 1;
    if (last) begin
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < 3; c++) m_word[d][k][c] = m_acc[d][k][c];
      case (m_state[d])
        0: if (enable) begin m_state[d] = 1; m_tcnt[d] = 0; m_ucnt[d] = 0; end
        1: if (!enable) begin m_state[d] = 0; m_pend[d] = 0; end
           else begin
             m_tcnt[d]++;
             if (m_tcnt[d] == TW) m_state[d] = 2;
           end
        default: if (!enable) begin m_state[d] = 0; m_pend[d] = 0; end
           else if (m_pend[d]) begin m_state[d] = 1; m_tcnt[d] = 0; m_pend[d] = 0; end
      endcase
    end
    m_phase[d] = last ? 0 : m_phase[d] + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  function automatic logic [64:0] obs0();
    return {ov0, ls0, wc0, ur0, ow0};
  endfunction

  function automatic logic [64:0] want0();
    logic [59:0] w;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 2; k++) w[c*20 + k*10 +: 10] = m_word[0][k][c];
    return {m_valid[0], 2'(m_state[0]), m_wclk[0], m_under[0], w};
  endfunction

  function automatic logic [84:0] obs1();
    return {ov1, ls1, wc1, ur1, ow1};
  endfunction

  function automatic logic [84:0] want1();
    logic [79:0] w;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 4; k++) w[c*40 + k*10 +: 10] = m_word[1][k][c];
    return {m_valid[1], 2'(m_state[1]), m_wclk[1], m_under[1], w};
  endfunction

  task automatic test_reset();
    reset = 1; enable = 0; train_req = 0; in_valid = 0; in_sym = '0;
    repeat (3) tick();
    n_checks++;
    if ({ov0, ls0, wc0, ur0} !== 5'b0) begin
      n_errs++; $display("FAIL reset_ctrl: got %b want 00000", {ov0, ls0, wc0, ur0});
    end
    n_checks++;
    if (ow0 !== {6{IDL}}) begin
      n_errs++; $display("FAIL reset_word: got %h want %h", ow0, {6{IDL}});
    end
    reset = 0;
  endtask

  task automatic test_idle();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ov0) pulses++;
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL idle_cyc%0d: got %h want %h", i, obs0(), want0());
      end
    end
    n_checks++;
    if (pulses != 10) begin
      n_errs++; $display("FAIL idle_pulses: got %0d want 10", pulses);
    end
  endtask

  task automatic run_training(input string tag);
    int words = 0;
    enable = 1; in_valid = 0;
    for (int i = 0; i < 100 && ls0 != 2; i++) begin
      tick();
      if (ov0 && ow0 === {6{TRN}}) words++;
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL %s_cyc%0d: got %h want %h", tag, i, obs0(), want0());
      end
    end
    n_checks++;
    if (ls0 !== 2'd2 || words != TW) begin
      n_errs++; $display("FAIL %s_done: got state %0d words %0d want state 2 words %0d", tag, ls0, words, TW);
    end
  endtask

  task automatic test_run_seq();
    in_valid = 1;
    for (int n = 0; n < 20; n++) begin
      for (int c = 0; c < 3; c++) in_sym[c*10 +: 10] = 10'(10'h100 + n + c*64);
      tick();
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL seq_n%0d: got %h want %h", n, obs0(), want0());
      end
    end
  endtask

  task automatic test_underrun();
    int exp_ur = 0, got_ur = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (m_phase[0] != 1);
      in_sym   = 30'($urandom);
      if (m_phase[0] == 1) exp_ur++;
      tick();
      if (ur0) got_ur++;
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL undr_cyc%0d: got %h want %h", i, obs0(), want0());
      end
`ifdef GTH_PACK_UNDERRUN_CNT_EN
      n_checks++;
      if (uc0 !== 16'(m_ucnt[0])) begin
        n_errs++; $display("FAIL undr_cnt%0d: got %0d want %0d", i, uc0, m_ucnt[0]);
      end
`endif
    end
    n_checks++;
    if (got_ur != exp_ur) begin
      n_errs++; $display("FAIL undr_pulses: got %0d want %0d", got_ur, exp_ur);
    end
    in_valid = 1;
  endtask

  task automatic test_train_req();
    if (m_phase[0] != 0) tick();
    train_req = 1; tick();
    train_req = 0; tick();
    n_checks++;
    if (ls0 !== 2'd1) begin
      n_errs++; $display("FAIL treq_train: got %0d want 1", ls0);
    end
    run_training("treq");
    in_valid = 1;
    if (m_phase[0] != 0) tick();
    train_req = 1; tick();
    train_req = 0; enable = 0; tick();
    n_checks++;
    if (ls0 !== 2'd0) begin
      n_errs++; $display("FAIL treq_drop: got %0d want 0", ls0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (obs0() !== want0() || (ov0 && ow0 === {6{TRN}})) begin
        n_errs++; $display("FAIL treq_idle%0d: got %h want %h", i, obs0(), want0());
      end
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_sym = 30'($urandom);
    if (m_phase[0] != 1) tick();
    reset = 1; tick();
    n_checks++;
    if (ov0 !== 1'b0 || ow0 !== {6{IDL}} || ls0 !== 2'd0) begin
      n_errs++; $display("FAIL rstmid: got v%b s%0d %h want v0 s0 %h", ov0, ls0, ow0, {6{IDL}});
    end
    reset = 0; enable = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL rstmid_cyc%0d: got %h want %h", i, obs0(), want0());
      end
    end
  endtask

  task automatic test_ratio4();
    int last_p = -1;
    reset = 1; enable = 0; repeat (2) tick();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (obs1() !== want1()) begin
        n_errs++; $display("FAIL r4_idle%0d: got %h want %h", i, obs1(), want1());
      end
      if (ov1) begin
        if (last_p >= 0) begin
          n_checks++;
          if (i - last_p != 4) begin
            n_errs++; $display("FAIL r4_period: got %0d want 4", i - last_p);
          end
        end
        last_p = i;
      end
    end
    enable = 1;
    for (int i = 0; i < 120; i++) begin
      in_valid = ($urandom_range(0, 4) != 0);
      in_sym   = 30'($urandom);
      tick();
      n_checks++;
      if (obs1() !== want1()) begin
        n_errs++; $display("FAIL r4_run%0d: got %h want %h", i, obs1(), want1());
      end
    end
    n_checks++;
    if (ls1 !== 2'd2) begin
      n_errs++; $display("FAIL r4_state: got %0d want 2", ls1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      enable    = ($urandom_range(0, 49) != 0);
      train_req = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_sym    = 30'($urandom);
      tick();
      n_checks++;
      if (obs0() !== want0()) begin
        n_errs++; $display("FAIL rnd0_%0d: got %h want %h", i, obs0(), want0());
      end
      n_checks++;
      if (obs1() !== want1()) begin
        n_errs++; $display("FAIL rnd1_%0d: got %h want %h", i, obs1(), want1());
      end
`ifdef GTH_PACK_UNDERRUN_CNT_EN
      n_checks++;
      if (uc0 !== 16'(m_ucnt[0]) || uc1 !== 16'(m_ucnt[1])) begin
        n_errs++; $display("FAIL rnd_ucnt%0d: got %0d/%0d want %0d/%0d", i, uc0, uc1, m_ucnt[0], m_ucnt[1]);
      end
`endif
    end
    train_req = 0;
  endtask

  initial begin
    test_reset();
    test_idle();
    run_training("train");
    test_run_seq();
    test_underrun();
    test_train_req();
    run_training("retrain");
    test_underrun();
    test_reset_mid();
    test_ratio4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end

endmodule
